// File: rtl/wb_gpio_pkg.sv
// Shared constants for the Wishbone GPIO bank: register offsets, reset values,
// pin limit and byte-lane helpers.
package wb_gpio_pkg;

    localparam int unsigned MAX_PINS = 64;
    localparam int unsigned DW       = 32;
    localparam int unsigned SW       = DW / 8;

    localparam logic [7:0] OFF_OUT_LO  = 8'h00;
    localparam logic [7:0] OFF_OUT_HI  = 8'h04;
    localparam logic [7:0] OFF_OEB_LO  = 8'h08;
    localparam logic [7:0] OFF_OEB_HI  = 8'h0C;
    localparam logic [7:0] OFF_IN_LO   = 8'h10;
    localparam logic [7:0] OFF_IN_HI   = 8'h14;
    localparam logic [7:0] OFF_EDGE_LO = 8'h18;
    localparam logic [7:0] OFF_EDGE_HI = 8'h1C;

    localparam logic [MAX_PINS-1:0] OUT_RST = '0;
    localparam logic [MAX_PINS-1:0] OEB_RST = '1;

    // Replace only the byte lanes whose select bit is set.
    function automatic logic [DW-1:0] lane_merge(input logic [DW-1:0] old_v,
                                                 input logic [DW-1:0] new_v,
                                                 input logic [SW-1:0] sel);
        logic [DW-1:0] res;
        for (int b = 0; b < int'(SW); b++) begin
            res[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return res;
    endfunction

    function automatic logic [DW-1:0] lane_mask(input logic [SW-1:0] sel);
        logic [DW-1:0] res;
        for (int b = 0; b < int'(SW); b++) begin
            res[8*b +: 8] = {8{sel[b]}};
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_gpio_bank_if.sv
// Wishbone classic slave bus bundle for the GPIO bank.
interface wb_gpio_bank_if;
    import wb_gpio_pkg::*;

    logic          wbs_stb_i;
    logic          wbs_cyc_i;
    logic          wbs_we_i;
    logic [SW-1:0] wbs_sel_i;
    logic [DW-1:0] wbs_dat_i;
    logic [DW-1:0] wbs_adr_i;
    logic          wbs_ack_o;
    logic [DW-1:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );

endinterface

// File: rtl/gpio_sync.sv
// Two-flop pad synchronizer with optional rising-edge pulse of the synchronized value.
module gpio_sync #(
    parameter int unsigned W       = 1,
    parameter bit          RISE_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q,
    output logic [W-1:0] o_rise_c
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

    generate
        if (RISE_EN) begin : g_rise
            logic [W-1:0] r_prev;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_prev <= '0;
                end else begin
                    r_prev <= r_sync;
                end
            end

            assign o_rise_c = r_sync & ~r_prev;
        end else begin : g_no_rise
            assign o_rise_c = '0;
        end
    endgenerate

endmodule

// File: rtl/wb_gpio_bank.sv
// Wishbone GPIO bank: OUT/OEB/IN registers and pad synchronizer.
// Define GPIO_EDGE_EN to build the EDGE capture registers and the edge interrupt.
module wb_gpio_bank
    import wb_gpio_pkg::*;
#(
    parameter int unsigned NPINS     = 38,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    wb_gpio_bank_if.slave    wbs,
    input  logic [NPINS-1:0] io_in,
    output logic [NPINS-1:0] io_out,
    output logic [NPINS-1:0] io_oeb,
    input  logic             active,
    output logic             irq
);

`ifdef GPIO_EDGE_EN
    localparam bit RISE_EN = 1'b1;
`else
    localparam bit RISE_EN = 1'b0;
`endif

    logic [7:0]          w_off;
    logic                w_hit;
    logic                w_accept;
    logic                w_wr;
    logic [DW-1:0]       w_rdata;
    logic [NPINS-1:0]    w_in;
    logic [NPINS-1:0]    w_rise;
    logic [NPINS-1:0]    w_edge;
    logic [NPINS-1:0]    w_edge_nxt;
    logic [NPINS-1:0]    w_out_nxt;
    logic [NPINS-1:0]    w_oeb_nxt;
    logic [MAX_PINS-1:0] w_out64;
    logic [MAX_PINS-1:0] w_oeb64;
    logic [MAX_PINS-1:0] w_in64;
    logic [MAX_PINS-1:0] w_edge64;

    logic [NPINS-1:0]    r_out;
    logic [NPINS-1:0]    r_oeb;
    logic [NPINS-1:0]    r_io_out;
    logic [NPINS-1:0]    r_io_oeb;
    logic                r_ack;
    logic [DW-1:0]       r_dat;
    logic                r_irq;
    logic                r_rst_hold;

    gpio_sync #(
        .W       (NPINS),
        .RISE_EN (RISE_EN)
    ) u_sync (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .i_d      (io_in),
        .o_q      (w_in),
        .o_rise_c (w_rise)
    );

    // A strobe held across reset must drop once before a new transfer is taken.
    assign w_off    = wbs.wbs_adr_i[7:0];
    assign w_hit    = (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign w_accept = wbs.wbs_stb_i & wbs.wbs_cyc_i & active & w_hit & ~r_ack & ~r_rst_hold;
    assign w_wr     = w_accept & wbs.wbs_we_i;

    assign w_out64  = MAX_PINS'(r_out);
    assign w_oeb64  = MAX_PINS'(r_oeb);
    assign w_in64   = MAX_PINS'(w_in);
    assign w_edge64 = MAX_PINS'(w_edge);

    always_comb begin
        w_rdata = '0;
        case (w_off)
            OFF_OUT_LO:  w_rdata = w_out64[31:0];
            OFF_OUT_HI:  w_rdata = w_out64[63:32];
            OFF_OEB_LO:  w_rdata = w_oeb64[31:0];
            OFF_OEB_HI:  w_rdata = w_oeb64[63:32];
            OFF_IN_LO:   w_rdata = w_in64[31:0];
            OFF_IN_HI:   w_rdata = w_in64[63:32];
            OFF_EDGE_LO: w_rdata = w_edge64[31:0];
            OFF_EDGE_HI: w_rdata = w_edge64[63:32];
            default:     w_rdata = '0;
        endcase
    end

    // Byte-lane writes; truncation to NPINS drops bits of absent pins.
    always_comb begin
        w_out_nxt = r_out;
        w_oeb_nxt = r_oeb;
        if (w_wr) begin
            case (w_off)
                OFF_OUT_LO: w_out_nxt = NPINS'({w_out64[63:32],
                              lane_merge(w_out64[31:0], wbs.wbs_dat_i, wbs.wbs_sel_i)});
                OFF_OUT_HI: w_out_nxt = NPINS'({lane_merge(w_out64[63:32], wbs.wbs_dat_i,
                              wbs.wbs_sel_i), w_out64[31:0]});
                OFF_OEB_LO: w_oeb_nxt = NPINS'({w_oeb64[63:32],
                              lane_merge(w_oeb64[31:0], wbs.wbs_dat_i, wbs.wbs_sel_i)});
                OFF_OEB_HI: w_oeb_nxt = NPINS'({lane_merge(w_oeb64[63:32], wbs.wbs_dat_i,
                              wbs.wbs_sel_i), w_oeb64[31:0]});
                default: ;
            endcase
        end
    end

`ifdef GPIO_EDGE_EN
    logic [NPINS-1:0] r_edge;
    logic [NPINS-1:0] w_clr;

    // W1C clear, but a rise in the same cycle keeps the bit set.
    always_comb begin
        w_clr = '0;
        if (w_wr) begin
            case (w_off)
                OFF_EDGE_LO: w_clr = NPINS'({32'h0, lane_mask(wbs.wbs_sel_i) & wbs.wbs_dat_i});
                OFF_EDGE_HI: w_clr = NPINS'({lane_mask(wbs.wbs_sel_i) & wbs.wbs_dat_i, 32'h0});
                default: ;
            endcase
        end
        w_edge_nxt = (r_edge & ~w_clr) | w_rise;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_edge <= '0;
        end else begin
            r_edge <= w_edge_nxt;
        end
    end

    assign w_edge = r_edge;
`else
    logic w_unused_rise;

    assign w_unused_rise = ^w_rise;
    assign w_edge        = '0;
    assign w_edge_nxt    = '0;
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_out      <= NPINS'(OUT_RST);
            r_oeb      <= NPINS'(OEB_RST);
            r_io_out   <= NPINS'(OUT_RST);
            r_io_oeb   <= NPINS'(OEB_RST);
            r_ack      <= 1'b0;
            r_dat      <= '0;
            r_irq      <= 1'b0;
            r_rst_hold <= 1'b1;
        end else begin
            r_out      <= w_out_nxt;
            r_oeb      <= w_oeb_nxt;
            r_io_out   <= active ? r_out : '0;
            r_io_oeb   <= active ? r_oeb : '1;
            r_ack      <= w_accept;
            r_dat      <= (w_accept && !wbs.wbs_we_i) ? w_rdata : '0;
            r_irq      <= active & (|w_edge_nxt);
            r_rst_hold <= r_rst_hold & wbs.wbs_stb_i;
        end
    end

    assign wbs.wbs_ack_o = r_ack;
    assign wbs.wbs_dat_o = r_dat;
    assign io_out        = r_io_out;
    assign io_oeb        = r_io_oeb;
    assign irq           = r_irq;

endmodule

// File: tb/tb_wb_gpio_bank.sv
// Directed bench for wb_gpio_bank (NPINS=38); edge expectations follow GPIO_EDGE_EN.
module tb_wb_gpio_bank;

`ifdef GPIO_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif
    localparam int unsigned NP = 38;

    logic          clk = 1'b0;
    logic          rst;
    logic [NP-1:0] io_in;
    logic [NP-1:0] io_out;
    logic [NP-1:0] io_oeb;
    logic          active;
    logic          irq;

    int n_vec = 0;
    int n_err = 0;

    wb_gpio_bank_if bus ();

    wb_gpio_bank #(
        .NPINS     (NP),
        .BASE_ADDR (32'h3000_0000)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs      (bus.slave),
        .io_in    (io_in),
        .io_out   (io_out),
        .io_oeb   (io_oeb),
        .active   (active),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One transfer, bounded to 10 cycles waiting for ack.
    task automatic xfer(input logic [31:0] adr, input logic we, input logic [31:0] wd,
                        input logic [3:0] sel, output logic [31:0] rd, output logic acked);
        @(negedge clk);
        bus.wbs_adr_i = adr;
        bus.wbs_we_i  = we;
        bus.wbs_dat_i = wd;
        bus.wbs_sel_i = sel;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        acked = 1'b0;
        rd    = '0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.wbs_ack_o) begin
                acked = 1'b1;
                rd    = bus.wbs_dat_o;
                break;
            end
        end
        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] off, input logic [31:0] exp);
        logic [31:0] d;
        logic        a;
        xfer(32'h3000_0000 | 32'(off), 1'b0, 32'h0, 4'h0, d, a);
        check({tag, "_ack"}, 64'(a), 64'(1'b1));
        check(tag, 64'(d), 64'(exp));
    endtask

    task automatic wr_chk(input string tag, input logic [7:0] off, input logic [31:0] wd,
                          input logic [3:0] sel);
        logic [31:0] d;
        logic        a;
        xfer(32'h3000_0000 | 32'(off), 1'b1, wd, sel, d, a);
        check({tag, "_ack"}, 64'(a), 64'(1'b1));
    endtask

    initial begin
        logic [31:0] d;
        logic        a;

        rst           = 1'b1;
        active        = 1'b1;
        io_in         = '0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'h0;
        bus.wbs_dat_i = 32'h0;
        bus.wbs_adr_i = 32'h0;

        idle(3);
        check("rst_oeb", 64'(io_oeb), 64'(38'h3F_FFFF_FFFF));
        check("rst_out", 64'(io_out), 64'h0);
        check("rst_ack", 64'(bus.wbs_ack_o), 64'h0);
        check("rst_dat", 64'(bus.wbs_dat_o), 64'h0);
        check("rst_irq", 64'(irq), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        rd_chk("oeb_lo_rst", 8'h08, 32'hFFFF_FFFF);
        rd_chk("oeb_hi_rst", 8'h0C, 32'h0000_003F);
        check("io_oeb_rst", 64'(io_oeb), 64'(38'h3F_FFFF_FFFF));

        wr_chk("wr_out_lo", 8'h00, 32'hA5A5_A5A5, 4'b0011);
        idle(1);
        check("io_out_lo", 64'(io_out), 64'(38'h00_0000_A5A5));
        rd_chk("out_lo", 8'h00, 32'h0000_A5A5);

        wr_chk("wr_out_hi", 8'h04, 32'hFFFF_FFFF, 4'b1111);
        rd_chk("out_hi", 8'h04, 32'h0000_003F);
        wr_chk("wr_oeb_lo", 8'h08, 32'h0000_0000, 4'b0001);
        rd_chk("oeb_lo", 8'h08, 32'hFFFF_FF00);
        idle(1);
        check("io_oeb_wr", 64'(io_oeb), 64'(38'h3F_FFFF_FF00));
        check("io_out_hi", 64'(io_out), 64'(38'h3F_0000_A5A5));

        // Strobe held six cycles: ack only every other cycle.
        idle(2);
        @(negedge clk);
        bus.wbs_adr_i = 32'h3000_0010;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("held_ack_c%0d", k + 1), 64'(bus.wbs_ack_o), 64'((k % 2) == 1));
        end
        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;

        // Rising pad edge on pin 37.
        idle(2);
        @(negedge clk);
        io_in[37] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("irq_early", 64'(irq), 64'h0);
        @(posedge clk);
        #1;
        check("irq_set", 64'(irq), 64'(EDGE));
        rd_chk("in_hi", 8'h14, 32'h0000_0020);
        rd_chk("in_lo", 8'h10, 32'h0000_0000);
        rd_chk("edge_hi", 8'h1C, EDGE ? 32'h0000_0020 : 32'h0);
        rd_chk("edge_lo", 8'h18, 32'h0);
        wr_chk("wr_edge_clr", 8'h1C, 32'h0000_0020, 4'hF);
        check("irq_clr", 64'(irq), 64'h0);
        rd_chk("edge_hi_clr", 8'h1C, 32'h0);

        // Clear landing in the same cycle as a new edge: the set wins.
        @(negedge clk);
        io_in[37] = 1'b0;
        idle(4);
        @(negedge clk);
        io_in[37] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        bus.wbs_adr_i = 32'h3000_001C;
        bus.wbs_we_i  = 1'b1;
        bus.wbs_dat_i = 32'h0000_0020;
        bus.wbs_sel_i = 4'hF;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        @(posedge clk);
        #1;
        check("race_ack", 64'(bus.wbs_ack_o), 64'h1);
        check("race_irq", 64'(irq), 64'(EDGE));
        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        rd_chk("race_edge", 8'h1C, EDGE ? 32'h0000_0020 : 32'h0);

        // Block deselected: pads released, bus ignored.
        @(negedge clk);
        active = 1'b0;
        idle(2);
        check("inact_oeb", 64'(io_oeb), 64'(38'h3F_FFFF_FFFF));
        check("inact_out", 64'(io_out), 64'h0);
        check("inact_irq", 64'(irq), 64'h0);
        xfer(32'h3000_0000, 1'b1, 32'h1234_5678, 4'hF, d, a);
        check("inact_noack", 64'(a), 64'h0);
        @(negedge clk);
        active = 1'b1;
        idle(2);
        check("react_out", 64'(io_out), 64'(38'h3F_0000_A5A5));
        check("react_oeb", 64'(io_oeb), 64'(38'h3F_FFFF_FF00));
        check("react_irq", 64'(irq), 64'(EDGE));
        rd_chk("react_out_lo", 8'h00, 32'h0000_A5A5);
        wr_chk("wr_edge_clr2", 8'h1C, 32'h0000_0020, 4'hF);

        // Address decode.
        xfer(32'h3000_0100, 1'b0, 32'h0, 4'h0, d, a);
        check("oow_noack", 64'(a), 64'h0);
        rd_chk("unmapped_40", 8'h40, 32'h0);

        // Reset in the middle of a transfer, strobe held through release.
        idle(2);
        @(negedge clk);
        bus.wbs_adr_i = 32'h3000_0008;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_ack", 64'(bus.wbs_ack_o), 64'h0);
        check("mid_rst_out", 64'(io_out), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("post_rst_noack%0d", k), 64'(bus.wbs_ack_o), 64'h0);
        end
        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        idle(1);
        rd_chk("post_rst_out", 8'h00, 32'h0);
        rd_chk("post_rst_oeb", 8'h0C, 32'h0000_003F);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
